// File: rtl/m4_pixel_streamer.sv
// m4_pixel_streamer: drains M4 one 128-bit word at a time and emits the
// 16 packed pixels per word as a valid/ready byte stream. A one-word
// prefetch buffer keeps the stream running at one pixel per cycle.
// Optional running checksum enabled by defining M4_STREAM_CHECKSUM_EN.
module m4_pixel_streamer #(
    parameter int          NUM_WORDS = 4096,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] M4_ReadBus,
    output logic [15:0]  M4_ReadAddress,
    output logic [7:0]   pixel_out,
    output logic         pixel_valid,
    input  logic         pixel_ready,
    output logic         busy,
    output logic         done,
    output logic [23:0]  checksum
);
    typedef enum logic [1:0] {IDLE, PRIME, STREAM, FINISH} state_t;

    localparam logic [16:0] WORDS     = 17'(NUM_WORDS);
    localparam logic [16:0] LAST_WORD = 17'(NUM_WORDS - 1);

    state_t         state_reg;
    logic [127:0]   shift_reg;
    logic [127:0]   prefetch_reg;
    logic [3:0]     byte_idx_reg;
    logic           shift_valid_reg;
    logic           prefetch_full_reg;
    logic           rd_req_reg;      // address presented this cycle
    logic           rd_data_reg;     // M4_ReadBus holds requested word this cycle
    logic [16:0]    issued_cnt_reg;  // words requested so far
    logic [16:0]    word_idx_reg;    // index of the word in the shift register

    logic xfer, last_byte, final_xfer, word_end, buf_consume;
    logic cap_to_shift, cap_to_buf, buf_full_next, issue;

    assign pixel_out   = shift_reg[7:0];
    assign pixel_valid = shift_valid_reg;

    // Transfer, capture routing and read-issue decisions for this edge.
    always_comb begin
        xfer          = (state_reg == STREAM) && shift_valid_reg && pixel_ready;
        last_byte     = (byte_idx_reg == 4'hF);
        final_xfer    = xfer && last_byte && (word_idx_reg == LAST_WORD);
        word_end      = xfer && last_byte && !final_xfer;
        buf_consume   = word_end && prefetch_full_reg;
        cap_to_shift  = rd_data_reg &&
                        ((state_reg == PRIME) ||
                         ((state_reg == STREAM) &&
                          (!shift_valid_reg || (word_end && !prefetch_full_reg))));
        cap_to_buf    = rd_data_reg && (state_reg == STREAM) && !cap_to_shift;
        buf_full_next = (prefetch_full_reg && !buf_consume) || cap_to_buf;
        // At most one read in flight, and only when its data has a free slot.
        issue         = ((state_reg == STREAM) || ((state_reg == PRIME) && rd_data_reg)) &&
                        (issued_cnt_reg < WORDS) && !rd_req_reg && !buf_full_next;
    end

    // Main control FSM, read pipeline, prefetch buffer and pixel shifter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            shift_reg         <= '0;
            prefetch_reg      <= '0;
            byte_idx_reg      <= '0;
            shift_valid_reg   <= 1'b0;
            prefetch_full_reg <= 1'b0;
            rd_req_reg        <= 1'b0;
            rd_data_reg       <= 1'b0;
            issued_cnt_reg    <= '0;
            word_idx_reg      <= '0;
            M4_ReadAddress    <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            rd_req_reg        <= 1'b0;
            rd_data_reg       <= rd_req_reg;
            done              <= 1'b0;
            prefetch_full_reg <= buf_full_next;
            if (cap_to_buf) begin
                prefetch_reg <= M4_ReadBus;
            end
            if (issue) begin
                M4_ReadAddress <= M4_ReadAddress + 16'd1;
                issued_cnt_reg <= issued_cnt_reg + 17'd1;
                rd_req_reg     <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        M4_ReadAddress <= BASE_ADDR;
                        issued_cnt_reg <= 17'd1;
                        rd_req_reg     <= 1'b1;
                        word_idx_reg   <= '0;
                        busy           <= 1'b1;
                        state_reg      <= PRIME;
                    end
                end
                PRIME: begin
                    if (rd_data_reg) begin
                        shift_reg       <= M4_ReadBus;
                        byte_idx_reg    <= '0;
                        shift_valid_reg <= 1'b1;
                        state_reg       <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        byte_idx_reg <= byte_idx_reg + 4'd1;
                        shift_reg    <= shift_reg >> 8;
                        if (final_xfer) begin
                            shift_valid_reg <= 1'b0;
                            done            <= 1'b1;
                            state_reg       <= FINISH;
                        end else if (last_byte) begin
                            if (prefetch_full_reg) begin
                                shift_reg    <= prefetch_reg;
                                word_idx_reg <= word_idx_reg + 17'd1;
                            end else if (rd_data_reg) begin
                                shift_reg    <= M4_ReadBus;
                                word_idx_reg <= word_idx_reg + 17'd1;
                            end else begin
                                shift_valid_reg <= 1'b0;
                            end
                        end
                    end else if (!shift_valid_reg && rd_data_reg) begin
                        shift_reg       <= M4_ReadBus;
                        byte_idx_reg    <= '0;
                        shift_valid_reg <= 1'b1;
                        word_idx_reg    <= word_idx_reg + 17'd1;
                    end
                end
                FINISH: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef M4_STREAM_CHECKSUM_EN
    logic [23:0] checksum_reg;

    // Sum of transferred pixels; cleared on start, held after done.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            checksum_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            checksum_reg <= '0;
        end else if (xfer) begin
            checksum_reg <= checksum_reg + {16'h0, pixel_out};
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = 24'h0;
`endif

endmodule

// File: tb/tb_m4_pixel_streamer.sv
// Directed bench for m4_pixel_streamer: one 4-word instance based at
// 16'hFFFE (address wrap, reset abort, throughput, back-pressure) and one
// single-word instance based at 16'h0010.
module tb_m4_pixel_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic a_start, a_ready, a_valid, a_busy, a_done;
    logic b_start, b_ready, b_valid, b_busy, b_done;
    logic [127:0] a_bus, b_bus;
    logic [15:0]  a_addr, b_addr;
    logic [7:0]   a_pix, b_pix;
    logic [23:0]  a_sum, b_sum;

    int checks = 0;
    int errors = 0;

`ifdef M4_STREAM_CHECKSUM_EN
    localparam logic [23:0] EXP_SUM_A = 24'h001FE0;
    localparam logic [23:0] EXP_SUM_B = 24'h000078;
`else
    localparam logic [23:0] EXP_SUM_A = 24'h0;
    localparam logic [23:0] EXP_SUM_B = 24'h0;
`endif

    m4_pixel_streamer #(.NUM_WORDS(4), .BASE_ADDR(16'hFFFE)) u_a (
        .clock(clk), .reset_n(rstn), .start(a_start), .M4_ReadBus(a_bus),
        .M4_ReadAddress(a_addr), .pixel_out(a_pix), .pixel_valid(a_valid),
        .pixel_ready(a_ready), .busy(a_busy), .done(a_done), .checksum(a_sum)
    );

    m4_pixel_streamer #(.NUM_WORDS(1), .BASE_ADDR(16'h0010)) u_b (
        .clock(clk), .reset_n(rstn), .start(b_start), .M4_ReadBus(b_bus),
        .M4_ReadAddress(b_addr), .pixel_out(b_pix), .pixel_valid(b_valid),
        .pixel_ready(b_ready), .busy(b_busy), .done(b_done), .checksum(b_sum)
    );

    // Memory image: byte i of word a is {a[3:0],4'h0}+i.
    function automatic logic [127:0] word_of(input logic [15:0] a);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = {a[3:0], 4'h0} + 8'(i);
        return w;
    endfunction

    // One-cycle read latency M4 models.
    always @(posedge clk) begin
        a_bus <= word_of(a_addr);
        b_bus <= word_of(b_addr);
    end

    // Monitors sampled on the falling edge.
    logic [7:0] a_log[$];
    logic [7:0] b_log[$];
    int a_busy_cyc = 0, a_valid_cyc = 0, a_done_cnt = 0, a_hold_viol = 0, a_addr_bad = 0;
    int b_busy_cyc = 0, b_done_cnt = 0, b_addr_chg = 0;
    logic       a_prev_stall = 1'b0;
    logic [7:0] a_prev_pix = 8'h0;
    logic [15:0] b_prev_addr = 16'h0;

    always @(negedge clk) begin
        if (rstn && a_valid && a_ready) a_log.push_back(a_pix);
        if (rstn && b_valid && b_ready) b_log.push_back(b_pix);
        if (a_busy) a_busy_cyc++;
        if (a_valid) a_valid_cyc++;
        if (a_done) a_done_cnt++;
        if (b_busy) b_busy_cyc++;
        if (b_done) b_done_cnt++;
        if (a_prev_stall && (!a_valid || a_pix !== a_prev_pix)) a_hold_viol++;
        a_prev_stall = a_valid && !a_ready;
        a_prev_pix   = a_pix;
        if (a_busy && !(a_addr == 16'hFFFE || a_addr == 16'hFFFF ||
                        a_addr == 16'h0000 || a_addr == 16'h0001)) a_addr_bad++;
        if (b_addr !== b_prev_addr) b_addr_chg++;
        b_prev_addr = b_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    task automatic start_b();
        b_start = 1'b1;
        step();
        b_start = 1'b0;
    endtask

    // Count steps until a_done is seen; returns -1 on timeout.
    task automatic wait_done_a(input int budget, input logic bp, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            if (bp) begin
                a_ready = (i % 4 == 1) || (i % 4 == 0);
                a_start = (i == 30);
            end
            step();
            if (a_done) begin
                k = i;
                break;
            end
        end
        a_start = 1'b0;
    endtask

    function automatic int bad_a(input int base);
        int bad = 0;
        for (int i = 0; i < 64; i++)
            if (a_log[base + i] !== 8'(8'hE0 + i)) bad++;
        return bad;
    endfunction

    int k, base, busy0, valid0, done0, chg0, n;

    initial begin
        rstn = 1'b0; a_start = 1'b0; b_start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        repeat (3) step();
        check("rst_a_addr", 32'(a_addr), 32'h0);
        check("rst_a_pix", 32'(a_pix), 32'h0);
        check("rst_a_valid", 32'(a_valid), 32'h0);
        check("rst_a_busy", 32'(a_busy), 32'h0);
        check("rst_a_done", 32'(a_done), 32'h0);
        check("rst_a_sum", 32'(a_sum), 32'h0);
        check("rst_b_busy", 32'(b_busy), 32'h0);
        rstn = 1'b1;
        step();
        $display("reset state checked");

        // Single word at 0x0010, ready high.
        b_ready = 1'b1;
        busy0 = b_busy_cyc;
        start_b();
        check("b_busy_t0", 32'(b_busy), 32'h1);
        check("b_addr_t0", 32'(b_addr), 32'h10);
        check("b_valid_t0", 32'(b_valid), 32'h0);
        step();
        check("b_valid_t1", 32'(b_valid), 32'h0);
        chg0 = b_addr_chg;
        step();
        check("b_valid_t2", 32'(b_valid), 32'h1);
        check("b_pix_t2", 32'(b_pix), 32'h0);
        k = -1;
        for (int i = 3; i <= 60; i++) begin
            step();
            if (b_done) begin k = i; break; end
        end
        check("b_done_cycle", 32'(k), 32'd18);
        step();
        check("b_busy_after", 32'(b_busy), 32'h0);
        check("b_done_pulse", 32'(b_done), 32'h0);
        step();
        check("b_busy_cycles", 32'(b_busy_cyc - busy0), 32'd19);
        check("b_done_count", 32'(b_done_cnt), 32'd1);
        check("b_addr_changes", 32'(b_addr_chg - chg0), 32'd0);
        check("b_xfer_count", 32'(b_log.size()), 32'd16);
        n = 0;
        for (int i = 0; i < 16 && i < b_log.size(); i++) if (b_log[i] !== 8'(i)) n++;
        check("b_pixels", 32'(n), 32'd0);
        check("b_sum", 32'(b_sum), 32'(EXP_SUM_B));
        $display("single word drain checked, done at step %0d", k);

        // Reset abort at pixel 20.
        a_ready = 1'b1;
        base = a_log.size();
        done0 = a_done_cnt;
        start_a();
        k = -1;
        for (int i = 0; i < 100; i++) begin
            if (a_log.size() - base >= 20) begin k = i; break; end
            step();
        end
        check("a_reach_pix20", 32'(a_log.size() - base), 32'd20);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("abort_addr", 32'(a_addr), 32'h0);
        check("abort_pix", 32'(a_pix), 32'h0);
        check("abort_valid", 32'(a_valid), 32'h0);
        check("abort_busy", 32'(a_busy), 32'h0);
        check("abort_sum", 32'(a_sum), 32'h0);
        repeat (10) step();
        check("abort_no_done", 32'(a_done_cnt - done0), 32'd0);
        $display("reset abort checked after %0d pixels", a_log.size() - base);

        // Full throughput drain (re-read from base after abort).
        base = a_log.size();
        busy0 = a_busy_cyc; valid0 = a_valid_cyc; done0 = a_done_cnt;
        start_a();
        wait_done_a(200, 1'b0, k);
        check("a_done_cycle", 32'(k), 32'd66);
        repeat (2) step();
        check("a_busy_cycles", 32'(a_busy_cyc - busy0), 32'd67);
        check("a_valid_cycles", 32'(a_valid_cyc - valid0), 32'd64);
        check("a_done_count", 32'(a_done_cnt - done0), 32'd1);
        check("a_xfer_count", 32'(a_log.size() - base), 32'd64);
        if (a_log.size() - base >= 64) check("a_pixels_wrap", 32'(bad_a(base)), 32'd0);
        check("a_sum", 32'(a_sum), 32'(EXP_SUM_A));
        check("a_addr_range", 32'(a_addr_bad), 32'd0);
        $display("full throughput drain checked, done at step %0d", k);

        // Back-pressure 1,0,0,1 with an ignored start mid-drain.
        base = a_log.size();
        done0 = a_done_cnt;
        a_ready = 1'b1;
        start_a();
        wait_done_a(400, 1'b1, k);
        check("bp_done_seen", 32'(k > 0), 32'h1);
        a_ready = 1'b1;
        repeat (3) step();
        check("bp_done_count", 32'(a_done_cnt - done0), 32'd1);
        check("bp_xfer_count", 32'(a_log.size() - base), 32'd64);
        if (a_log.size() - base >= 64) check("bp_pixels", 32'(bad_a(base)), 32'd0);
        check("bp_hold", 32'(a_hold_viol), 32'd0);
        check("bp_sum", 32'(a_sum), 32'(EXP_SUM_A));
        check("bp_addr_range", 32'(a_addr_bad), 32'd0);
        check("bp_idle", 32'(a_busy), 32'h0);
        $display("back-pressure drain checked, done at step %0d", k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
